// File: rtl/imem_pkg.sv
// Shared types and helpers for the instruction-memory responder.
package imem_pkg;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } imem_state_t;

  // addi x0,x0,0 -- returned in place of data on a faulting fetch
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

  // Misaligned, or beyond the last stored word (no wrap-around aliasing).
  function automatic logic is_fetch_fault(input logic [31:0] addr, input int unsigned depth);
    logic [33:0] limit;
    limit = 34'(depth) << 2;
    return (addr[1:0] != 2'b00) || (34'(addr) >= limit);
  endfunction

endpackage

// File: rtl/imem_array.sv
// Instruction storage: one write port, one registered read port, no reset.
// Ports:
//   clk            rising-edge clock
//   we/waddr/wdata word write
//   re/raddr       read enable / word address; rdata valid the cycle after re
//   rdata          registered read data, holds while re is low
module imem_array #(
  parameter  int unsigned DEPTH_WORDS = 256,
  localparam int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/imem_responder.sv
// Fetch-side instruction-memory responder: boot-time load port, then
// one-cycle-latency valid/ready fetches with misalign/range fault reporting.
// Ports:
//   clk, rst                   clock, synchronous active-low reset
//   req_valid/req_ready/req_addr   fetch request (byte address)
//   rsp_valid/rsp_ready        response handshake
//   rsp_instr/rsp_fault        response payload
//   ld_en/ld_addr/ld_data      boot-time word write
//   ld_done                    leave BOOT and start serving fetches
//   ld_err                     sticky: load attempted while running
//   ld_count                   words written since reset, saturating
//   running                    high in RUN
module imem_responder
  import imem_pkg::*;
#(
  parameter  int unsigned DEPTH_WORDS = 256,
  parameter  logic [31:0] NOP_INSTR   = NOP_INSTR_DEFAULT,
  localparam int unsigned AW          = $clog2(DEPTH_WORDS),
  localparam int unsigned CW          = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [31:0]   req_addr,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_instr,
  output logic          rsp_fault,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [31:0]   ld_data,
  input  logic          ld_done,
  output logic          ld_err,
  output logic [CW-1:0] ld_count,
  output logic          running
);

  imem_state_t state;
  imem_state_t state_nxt;

  logic        accept;
  logic        fetch_fault;
  logic        ram_we;
  logic        ram_re;
  logic [31:0] ram_rdata;
  logic        rsp_from_ram;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state <= BOOT;
    else      state <= state_nxt;
  end

  // Next state: RUN is left only through reset
  always_comb begin
    state_nxt = state;
    case (state)
      BOOT:    if (ld_done) state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = BOOT;
    endcase
  end

  // FSM-derived outputs
  always_comb begin
    running   = 1'b0;
    req_ready = 1'b0;
    if (state == RUN) begin
      running   = 1'b1;
      req_ready = !rsp_valid || rsp_ready;
    end
  end

  assign accept      = rst && req_valid && req_ready;
  assign fetch_fault = is_fetch_fault(req_addr, DEPTH_WORDS);
  assign ram_re      = accept && !fetch_fault;
  assign ram_we      = rst && ld_en && (state == BOOT);

  imem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ld_addr),
    .wdata (ld_data),
    .re    (ram_re),
    .raddr (req_addr[AW+1:2]),
    .rdata (ram_rdata)
  );

  // Response slot: refilled on accept, emptied on consume-without-refill
  always_ff @(posedge clk) begin
    if (!rst) begin
      rsp_valid    <= 1'b0;
      rsp_fault    <= 1'b0;
      rsp_from_ram <= 1'b0;
    end else if (accept) begin
      rsp_valid    <= 1'b1;
      rsp_fault    <= fetch_fault;
      rsp_from_ram <= !fetch_fault;
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid    <= 1'b0;
    end
  end

  // RAM data register holds between accepts, so the payload is stable under stall
  assign rsp_instr = rsp_from_ram ? ram_rdata : (rsp_fault ? NOP_INSTR : 32'h0);

  // Load bookkeeping
  always_ff @(posedge clk) begin
    if (!rst) begin
      ld_err   <= 1'b0;
      ld_count <= '0;
    end else begin
      if (ld_en && (state == RUN)) ld_err <= 1'b1;
      if (ram_we && (ld_count != CW'(DEPTH_WORDS))) ld_count <= ld_count + CW'(1);
    end
  end

endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Instruction-memory responder on the fetch side of the single-cycle core.
- Accepts fetch requests (byte address from the program counter) and returns the 32-bit instruction word one cycle later over a valid/ready handshake.
- Has a boot-time load port for filling the memory before execution starts.
- Flags misaligned and out-of-range fetches instead of returning garbage.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit instruction words stored (power of two).
- NOP_INSTR, 32'h0000_0013, word returned on a faulting fetch (addi x0,x0,0).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-low
- req_valid  in  1  fetch request valid
- req_ready  out  1  responder can accept a request this cycle
- req_addr  in  32  fetch byte address
- rsp_valid  out  1  response valid
- rsp_ready  in  1  consumer accepts response
- rsp_instr  out  32  fetched instruction word
- rsp_fault  out  1  response is a fault (misaligned or out of range)
- ld_en  in  1  load-port write strobe
- ld_addr  in  $clog2(DEPTH_WORDS)  load word address
- ld_data  in  32  load word data
- ld_done  in  1  pulse: loading finished, enter RUN
- ld_err  out  1  sticky: write attempted outside BOOT
- ld_count  out  $clog2(DEPTH_WORDS)+1  words written since reset, saturating
- running  out  1  high in RUN state

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst: sampled only at posedge clk; rst=0 resets the block.
- Reset values: state=BOOT, rsp_valid=0, rsp_instr=0, rsp_fault=0, ld_err=0, ld_count=0, running=0. Memory contents are not reset and are retained across reset.
- States: BOOT and RUN.
  - BOOT -> RUN on ld_done=1.
  - RUN -> BOOT only via reset.
  - running = (state==RUN).
- Load port:
  - In BOOT, ld_en=1 writes ld_data to word ld_addr at posedge. ld_count increments, saturating at DEPTH_WORDS.
  - Same-cycle ld_en and ld_done: the write completes and the state moves to RUN.
  - ld_en in RUN: no write; ld_err set to 1 and held until reset.
  - Repeated writes to the same address: last write wins; each write still counts.
- Fetch handshake:
  - req_ready = running && (!rsp_valid || rsp_ready).
  - A request is accepted when req_valid && req_ready at a posedge.
  - Latency: exactly 1 cycle. rsp_valid rises on the cycle after acceptance.
  - The response holds stable (instr, fault) while rsp_valid && !rsp_ready.
  - A response is consumed when rsp_valid && rsp_ready. If a new request is accepted in the same cycle, rsp_valid stays 1 with the new data (back-to-back, one word per cycle).
  - If the response is consumed with no new acceptance, rsp_valid falls to 0.
  - In BOOT, req_ready=0 and requests are not accepted. The requester must hold req_valid/req_addr until accepted.
- Address rules:
  - Word index = req_addr[$clog2(DEPTH_WORDS)+1:2].
  - Fault if req_addr[1:0] != 0, or if req_addr >= 4*DEPTH_WORDS (any upper bit set).
  - On fault: rsp_fault=1, rsp_instr=NOP_INSTR, no memory read side effect.
  - Otherwise: rsp_fault=0, rsp_instr = memory word.
  - No wrap-around: an address of 4*DEPTH_WORDS faults; it does not alias to word 0.
- Read-during-load: not possible, since fetch is blocked in BOOT.
- Reset mid-operation: a pending response is dropped (rsp_valid=0 next cycle) and the state returns to BOOT. Memory keeps the program, so only ld_done is needed to rerun.

Decomposition:
- Package imem_pkg:
  - state enum imem_state_t {BOOT, RUN}
  - NOP_INSTR default constant
  - function is_fetch_fault(addr, depth)
- Sub-module imem_array: single-port-write, single-port-read synchronous RAM (DEPTH_WORDS x 32, registered read, no reset).
- The top holds the FSM, handshake, fault path and counters.

Test Plan:
- Reset with rst=0 for 2 cycles -> all outputs 0, req_ready=0, running=0.
- BOOT load: words 0..3 = 32'h00500093, 32'h00A00113, 32'h002081B3, 32'h0000006F, then ld_done -> ld_count=4, running=1. Fetch 0x0,0x4,0x8,0xC back-to-back with rsp_ready=1 -> rsp_valid every cycle starting 1 cycle after the first accept, instructions in order, rsp_fault=0.
- Backpressure: rsp_ready=0 for 3 cycles after a fetch of 0x4 -> rsp_instr held at 32'h00A00113, req_ready=0. Release -> consumed, next request accepted the same cycle.
- Faults: fetch 0x6 -> rsp_fault=1, rsp_instr=32'h00000013. Fetch 0x400 (DEPTH_WORDS=256) -> fault, no alias to word 0.
- Load after RUN: ld_en=1, ld_addr=0, ld_data=32'hFFFFFFFF -> ld_err=1. Fetch 0x0 still returns 32'h00500093.
- Reset mid-response with rsp_valid=1, rsp_ready=0 -> rsp_valid=0, state BOOT. ld_done alone -> fetch 0x8 returns 32'h002081B3 (memory retained).
